// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and constants for the rs232 transmitter and receiver
package rs232_pkg;
  localparam int RS232_DATA_BITS = 8;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;
endpackage

// File: rtl/rs232_baud_tick.sv
// rs232_baud_tick: loadable down-counter that flags the last cycle of a bit period
module rs232_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LOAD = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] count_q, count_d;
  assign tick = count_q == '0;
  always_comb count_d = restart ? LOAD : tick ? count_q : count_q - 1'b1;
  always_ff @(posedge clk_in) begin
    if (rst_in) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/rs232_tx.sv
// rs232_tx: UART transmitter with a one-entry holding register for back-to-back frames
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [RS232_DATA_BITS-1:0] data_in,
  input  logic                       ctrl_wdata,
  output logic                       ctrl_wready,
  output logic                       txd_out,
  output logic                       tx_busy,
  output logic                       frame_done
);
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  tx_state_t state_q, state_d;
  logic [RS232_DATA_BITS-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic full_q, full_d, stop_q, stop_d, par_q, par_d, txd_q, txd_d;
  logic tick, accept, done, xfer, advance;
  rs232_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .restart(xfer || advance),
    .tick   (tick)
  );
  always_comb begin
    accept = ctrl_wdata && !full_q;
    done = state_q == TX_STOP && tick && stop_q == 1'(STOP_BITS - 1);
    xfer = full_q && (state_q == TX_IDLE || done);
    advance = tick && state_q != TX_IDLE;
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    stop_d = stop_q;
    par_d = par_q;
    if (xfer) begin
      state_d = TX_START;
      shift_d = hold_q;
      par_d = PARITY == PAR_ODD ? ~^hold_q : ^hold_q;
    end else if (advance) begin
      case (state_q)
        TX_START: begin
          state_d = TX_DATA;
          bit_d = '0;
          stop_d = 1'b0;
        end
        TX_DATA: begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(RS232_DATA_BITS - 1)) state_d = PARITY != PAR_NONE ? TX_PARITY : TX_STOP;
        end
        TX_PARITY: state_d = TX_STOP;
        TX_STOP: begin
          state_d = done ? TX_IDLE : state_q;
          stop_d = 1'b1;
        end
        default: state_d = TX_IDLE;
      endcase
    end
    hold_d = accept ? data_in : hold_q;
    full_d = accept || (full_q && !xfer);
    // The line register follows the next state so each bit appears with its entry edge
    txd_d = state_d == TX_START ? 1'b0 :
            state_d == TX_DATA ? shift_d[0] :
            state_d == TX_PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= TX_IDLE;
      hold_q <= '0;
      shift_q <= '0;
      bit_q <= '0;
      full_q <= 1'b0;
      stop_q <= 1'b0;
      par_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      full_q <= full_d;
      stop_q <= stop_d;
      par_q <= par_d;
      txd_q <= txd_d;
    end
  end
  assign ctrl_wready = !full_q;
  assign txd_out = txd_q;
  assign tx_busy = state_q != TX_IDLE;
  assign frame_done = done;
endmodule
